// File: rtl/wshb_stream_pkg.sv
// ---------------------------------------------------------------------------
// Module : wshb_stream_pkg
// Brief  : Shared Wishbone cycle-type codes, stream entry layout, FIFO helpers.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

package wshb_stream_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam int ENTRY_ADR_W = 32;
  localparam int ENTRY_DW    = 32;
  localparam int ENTRY_SEL_W = 4;

  typedef struct packed {
    logic [ENTRY_ADR_W-1:0] adr;
    logic [ENTRY_DW-1:0]    dat;
    logic [ENTRY_SEL_W-1:0] sel;
  } stream_entry_t;

  // Occupancy counter must represent 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/wshb_stream_responder_sync_fifo.sv
// ---------------------------------------------------------------------------
// Module : sync_fifo
// Brief  : Single-clock FIFO with registered head, full/empty/count outputs.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module sync_fifo
  import wshb_stream_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_next;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] head_q;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == CW'(DEPTH));
    do_push = push & ~full;
    do_pop  = pop & ~empty;
    rd_next = do_pop ? rd_ptr + 1'b1 : rd_ptr;
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      head_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      rd_ptr <= rd_next;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      // Bypass when the word being written becomes the new head this edge.
      if (do_push && (wr_ptr == rd_next)) begin
        head_q <= push_data;
      end else begin
        head_q <= mem[rd_next];
      end
    end
  end

  assign head_data = head_q;
  assign count     = count_q;

endmodule

`default_nettype wire

// File: rtl/wshb_stream_responder.sv
// ---------------------------------------------------------------------------
// Module : wshb_stream_responder
// Brief  : Wishbone B4 write responder feeding a valid/ready stream via FIFO.
//          Define WSHB_STREAM_ERR_EN to answer reads and sel==0 writes with err.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module wshb_stream_responder
  import wshb_stream_pkg::*;
#(
  parameter int DATA_BYTES = 4,
  parameter int ADR_W      = 32,
  parameter int DEPTH      = 8
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic                    wb_cyc,
  input  logic                    wb_stb,
  input  logic                    wb_we,
  input  logic [ADR_W-1:0]        wb_adr,
  input  logic [8*DATA_BYTES-1:0] wb_dat_ms,
  input  logic [DATA_BYTES-1:0]   wb_sel,
  input  logic [2:0]              wb_cti,
  input  logic [1:0]              wb_bte,
  output logic [8*DATA_BYTES-1:0] wb_dat_sm,
  output logic                    wb_ack,
  output logic                    wb_err,
  output logic                    wb_rty,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ADR_W-1:0]        out_adr,
  output logic [8*DATA_BYTES-1:0] out_dat,
  output logic [DATA_BYTES-1:0]   out_sel,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  localparam int DW = 8 * DATA_BYTES;
  localparam int EW = ADR_W + DW + DATA_BYTES;

  logic          req;
  logic          burst;
  logic          sel_ok;
  logic          push;
  logic          pop;
  logic          rd_hit;
  logic          err_hit;
  logic          fifo_full;
  logic          fifo_empty;
  logic          ack_q;
  logic          err_q;
  logic          burst_q;
  logic [DW-1:0] dat_sm_q;
  logic [EW-1:0] head;
  logic          unused_bte;

  assign unused_bte = ^wb_bte;

  always_comb begin
    req   = wb_cyc & wb_stb;
    burst = (wb_cti == CTI_INCR);
`ifdef WSHB_STREAM_ERR_EN
    sel_ok  = |wb_sel;
    rd_hit  = 1'b0;
    err_hit = req & ~ack_q & ~err_q & (~wb_we | ~sel_ok);
`else
    sel_ok  = 1'b1;
    rd_hit  = req & ~wb_we & ~ack_q;
    err_hit = 1'b0;
`endif
    // burst_q lets the end-of-burst word follow an incrementing word back to back.
    push = req & wb_we & sel_ok & ~fifo_full & (~ack_q | burst | burst_q);
    pop  = out_ready & ~fifo_empty;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      burst_q  <= 1'b0;
      dat_sm_q <= '0;
    end else begin
      ack_q    <= push | rd_hit;
      err_q    <= err_hit;
      burst_q  <= push & burst;
      dat_sm_q <= rd_hit ? DW'(fifo_count) : '0;
    end
  end

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (sys_clk),
    .rst_n     (sys_rst_n),
    .push      (push),
    .push_data ({wb_adr, wb_dat_ms, wb_sel}),
    .pop       (pop),
    .head_data (head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  assign {out_adr, out_dat, out_sel} = head;
  assign out_valid = ~fifo_empty;
  assign wb_ack    = ack_q;
  assign wb_err    = err_q;
  assign wb_rty    = 1'b0;
  assign wb_dat_sm = dat_sm_q;

endmodule

`default_nettype wire

// File: tb/tb_wshb_stream_responder.sv
// ---------------------------------------------------------------------------
// Module : tb_wshb_stream_responder
// Brief  : Vector table plus burst, full-FIFO and reset sequences.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_wshb_stream_responder;
  import wshb_stream_pkg::*;

`ifdef WSHB_STREAM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, cyc, stb, we, ready;
  logic [31:0] adr, dat_ms;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [31:0] dat_sm, out_adr, out_dat;
  logic        ack, err, rty, out_valid;
  logic [3:0]  out_sel;
  logic [3:0]  cnt;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  wshb_stream_responder #(.DATA_BYTES(4), .ADR_W(32), .DEPTH(8)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .wb_cyc(cyc), .wb_stb(stb), .wb_we(we),
    .wb_adr(adr), .wb_dat_ms(dat_ms), .wb_sel(sel), .wb_cti(cti), .wb_bte(bte),
    .wb_dat_sm(dat_sm), .wb_ack(ack), .wb_err(err), .wb_rty(rty),
    .out_valid(out_valid), .out_ready(ready), .out_adr(out_adr), .out_dat(out_dat),
    .out_sel(out_sel), .fifo_count(cnt)
  );

  typedef struct {
    logic        rst_n, cyc, stb, we;
    logic [31:0] adr, dat;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic        ready;
    logic        e_ack, e_err;
    logic [31:0] e_dsm;
    logic        e_valid, chk_head;
    logic [31:0] e_adr, e_dat;
    logic [3:0]  e_sel, e_cnt;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] rx[$];

  function automatic vec_t mk(input logic r, c, s, w, input logic [31:0] a, d,
                              input logic [3:0] sl, input logic [2:0] ct, input logic rd,
                              input logic eak, eer, input logic [31:0] eds,
                              input logic ev, ech, input logic [31:0] ea, ed,
                              input logic [3:0] es, ec);
    vec_t v;
    v.rst_n = r; v.cyc = c; v.stb = s; v.we = w; v.adr = a; v.dat = d;
    v.sel = sl; v.cti = ct; v.ready = rd; v.e_ack = eak; v.e_err = eer;
    v.e_dsm = eds; v.e_valid = ev; v.chk_head = ech; v.e_adr = ea;
    v.e_dat = ed; v.e_sel = es; v.e_cnt = ec;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_rec();
    if (out_valid && ready) rx.push_back(out_dat);
    step();
  endtask

  task automatic idle();
    cyc = 0; stb = 0; we = 0; adr = 0; dat_ms = 0; sel = 0; cti = CTI_CLASSIC;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [2:0] c);
    cyc = 1; stb = 1; we = 1; adr = a; dat_ms = d; sel = 4'hF; cti = c;
  endtask

  task automatic burst_word(input int i);
    wr(32'h200 + 32'(4 * i), 32'hD000_0000 + 32'(i), (i == 9) ? CTI_EOB : CTI_INCR);
  endtask

  initial begin
    int idx;
    int acks;
    rst_n = 0; ready = 0; bte = 2'b00;
    idle();

    tbl.push_back(mk(0,0,0,0, 0,0,0,CTI_CLASSIC,0, 0,0,0, 0,0, 0,0,0, 0));
    tbl.push_back(mk(1,0,0,0, 0,0,0,CTI_CLASSIC,0, 0,0,0, 0,0, 0,0,0, 0));
    tbl.push_back(mk(1,1,1,1, 'h10,'hCAFE0001,'hF,CTI_CLASSIC,1, 1,0,0, 1,1, 'h10,'hCAFE0001,'hF, 1));
    tbl.push_back(mk(1,0,0,0, 0,0,0,CTI_CLASSIC,1, 0,0,0, 0,0, 0,0,0, 0));
    tbl.push_back(mk(1,1,1,1, 'h100,'hA0,'hF,CTI_INCR,0, 1,0,0, 1,1, 'h100,'hA0,'hF, 1));
    tbl.push_back(mk(1,1,1,1, 'h104,'hA1,'hF,CTI_INCR,0, 1,0,0, 1,1, 'h100,'hA0,'hF, 2));
    tbl.push_back(mk(1,1,1,1, 'h108,'hA2,'hF,CTI_INCR,0, 1,0,0, 1,1, 'h100,'hA0,'hF, 3));
    tbl.push_back(mk(1,1,1,1, 'h10C,'hA3,'hF,CTI_EOB,0,  1,0,0, 1,1, 'h100,'hA0,'hF, 4));
    tbl.push_back(mk(1,0,0,0, 0,0,0,CTI_CLASSIC,0, 0,0,0, 1,1, 'h100,'hA0,'hF, 4));
    tbl.push_back(mk(1,0,0,0, 0,0,0,CTI_CLASSIC,1, 0,0,0, 1,1, 'h104,'hA1,'hF, 3));
    tbl.push_back(mk(1,0,0,0, 0,0,0,CTI_CLASSIC,1, 0,0,0, 1,1, 'h108,'hA2,'hF, 2));
    tbl.push_back(mk(1,0,0,0, 0,0,0,CTI_CLASSIC,1, 0,0,0, 1,1, 'h10C,'hA3,'hF, 1));
    tbl.push_back(mk(1,0,0,0, 0,0,0,CTI_CLASSIC,1, 0,0,0, 0,0, 0,0,0, 0));
    tbl.push_back(mk(1,1,1,1, 'h20,'hB0,'hF,CTI_CLASSIC,0, 1,0,0, 1,1, 'h20,'hB0,'hF, 1));
    tbl.push_back(mk(1,0,0,0, 0,0,0,CTI_CLASSIC,0, 0,0,0, 1,1, 'h20,'hB0,'hF, 1));
    tbl.push_back(mk(1,1,1,1, 'h24,'hB1,'hF,CTI_CLASSIC,0, 1,0,0, 1,1, 'h20,'hB0,'hF, 2));
    tbl.push_back(mk(1,0,0,0, 0,0,0,CTI_CLASSIC,0, 0,0,0, 1,1, 'h20,'hB0,'hF, 2));
    tbl.push_back(mk(1,1,1,1, 'h28,'hB2,'hF,CTI_CLASSIC,0, 1,0,0, 1,1, 'h20,'hB0,'hF, 3));
    tbl.push_back(mk(1,0,0,0, 0,0,0,CTI_CLASSIC,0, 0,0,0, 1,1, 'h20,'hB0,'hF, 3));
    tbl.push_back(mk(1,1,1,0, 0,0,'hF,CTI_CLASSIC,0, !ERR_EN,ERR_EN,ERR_EN ? 0 : 3,
                     1,1, 'h20,'hB0,'hF, 3));
    tbl.push_back(mk(1,0,0,0, 0,0,0,CTI_CLASSIC,0, 0,0,0, 1,1, 'h20,'hB0,'hF, 3));
    tbl.push_back(mk(1,0,0,0, 0,0,0,CTI_CLASSIC,1, 0,0,0, 1,1, 'h24,'hB1,'hF, 2));
    tbl.push_back(mk(1,0,0,0, 0,0,0,CTI_CLASSIC,1, 0,0,0, 1,1, 'h28,'hB2,'hF, 1));
    tbl.push_back(mk(1,0,0,0, 0,0,0,CTI_CLASSIC,1, 0,0,0, 0,0, 0,0,0, 0));
    tbl.push_back(mk(1,0,1,1, 'h30,'hDD,'hF,CTI_CLASSIC,0, 0,0,0, 0,0, 0,0,0, 0));
    tbl.push_back(mk(1,1,1,1, 'h34,'hC0,'h0,CTI_CLASSIC,0, !ERR_EN,ERR_EN,0,
                     !ERR_EN,!ERR_EN, 'h34,'hC0,'h0, ERR_EN ? 0 : 1));
    tbl.push_back(mk(1,0,0,0, 0,0,0,CTI_CLASSIC,1, 0,0,0, 0,0, 0,0,0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      rst_n = tbl[i].rst_n; cyc = tbl[i].cyc; stb = tbl[i].stb; we = tbl[i].we;
      adr = tbl[i].adr; dat_ms = tbl[i].dat; sel = tbl[i].sel; cti = tbl[i].cti;
      ready = tbl[i].ready;
      step();
      chk($sformatf("v%0d ack", i), 32'(ack), 32'(tbl[i].e_ack));
      chk($sformatf("v%0d err", i), 32'(err), 32'(tbl[i].e_err));
      chk($sformatf("v%0d rty", i), 32'(rty), 32'd0);
      chk($sformatf("v%0d dat_sm", i), dat_sm, tbl[i].e_dsm);
      chk($sformatf("v%0d valid", i), 32'(out_valid), 32'(tbl[i].e_valid));
      chk($sformatf("v%0d count", i), 32'(cnt), 32'(tbl[i].e_cnt));
      if (tbl[i].chk_head) begin
        chk($sformatf("v%0d out_adr", i), out_adr, tbl[i].e_adr);
        chk($sformatf("v%0d out_dat", i), out_dat, tbl[i].e_dat);
        chk($sformatf("v%0d out_sel", i), 32'(out_sel), 32'(tbl[i].e_sel));
      end
    end

    // 10-word burst into an 8-entry FIFO with the consumer stalled.
    idx = 0; acks = 0; ready = 0; rx.delete();
    for (int c = 0; c < 12; c++) begin
      if (idx < 10) burst_word(idx); else idle();
      step_rec();
      if (ack) begin acks++; idx++; end
    end
    chk("burst fill acks", 32'(acks), 32'd8);
    chk("burst fill count", 32'(cnt), 32'd8);
    chk("burst full ack low", 32'(ack), 32'd0);
    ready = 1; burst_word(idx); step_rec();
    chk("full pop edge ack", 32'(ack), 32'd0);
    chk("full pop edge count", 32'(cnt), 32'd7);
    if (ack) idx++;
    ready = 0; burst_word(idx); step_rec();
    chk("after pop ack", 32'(ack), 32'd1);
    chk("after pop count", 32'(cnt), 32'd8);
    if (ack) idx++;
    ready = 1;
    for (int c = 0; c < 40 && rx.size() < 10; c++) begin
      if (idx < 10) burst_word(idx); else idle();
      step_rec();
      if (ack) idx++;
    end
    idle();
    chk("burst words delivered", 32'(rx.size()), 32'd10);
    for (int i = 0; i < rx.size(); i++)
      chk($sformatf("burst word %0d", i), rx[i], 32'hD000_0000 + 32'(i));
    step();
    chk("burst drained count", 32'(cnt), 32'd0);

    // Reset on the third word of a burst with two words queued.
    ready = 0;
    wr(32'h500, 32'h11, CTI_INCR); step();
    wr(32'h504, 32'h12, CTI_INCR); step();
    chk("pre-reset count", 32'(cnt), 32'd2);
    wr(32'h508, 32'h13, CTI_INCR); rst_n = 0; step();
    chk("mid-burst reset ack", 32'(ack), 32'd0);
    chk("mid-burst reset valid", 32'(out_valid), 32'd0);
    chk("mid-burst reset count", 32'(cnt), 32'd0);
    rst_n = 1; idle(); step();
    chk("post-reset idle ack", 32'(ack), 32'd0);
    ready = 1; wr(32'h40, 32'h5555AAAA, CTI_CLASSIC); step();
    chk("post-reset write ack", 32'(ack), 32'd1);
    chk("post-reset out_adr", out_adr, 32'h40);
    chk("post-reset out_dat", out_dat, 32'h5555AAAA);
    idle(); step();
    chk("post-reset ack drop", 32'(ack), 32'd0);
    chk("post-reset count", 32'(cnt), 32'd0);

    // Full FIFO, classic write pending, consumer ready.
    ready = 0;
    for (int k = 0; k < 8; k++) begin
      wr(32'h300 + 32'(4 * k), 32'hE0 + 32'(k), (k == 7) ? CTI_EOB : CTI_INCR);
      step();
    end
    idle(); step();
    chk("fill count", 32'(cnt), 32'd8);
    ready = 1; wr(32'h400, 32'hE8, CTI_CLASSIC); step();
    chk("full+pop no ack", 32'(ack), 32'd0);
    chk("full+pop count", 32'(cnt), 32'd7);
    step();
    chk("next edge ack", 32'(ack), 32'd1);
    chk("push+pop count unchanged", 32'(cnt), 32'd7);
    chk("push+pop head order", out_dat, 32'hE2);
    idle(); ready = 0; step();
    chk("classic single ack", 32'(ack), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
